// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1 without wrapping.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder cell used by the serial adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ ci;
    assign cout = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sumsr_q, sumsr_d;
    logic [WIDTH-1:0] sumhold_q, sumhold_d;
    logic             carry_q, carry_d;
    logic             couthold_q, couthold_d;
    logic             fa_s, fa_c;
    logic [WIDTH-1:0] sumsr_shift;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .ci   (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    if (WIDTH == 1) begin : g_w1
        assign sumsr_shift = fa_s;
    end else begin : g_wn
        assign sumsr_shift = {fa_s, sumsr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        a_d        = a_q;
        b_d        = b_q;
        sumsr_d    = sumsr_q;
        carry_d    = carry_q;
        sumhold_d  = sumhold_q;
        couthold_d = couthold_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d      = ovf_q;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = ci_in;
                    count_d = '0;
                    sumsr_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sumsr_d = sumsr_shift;
                carry_d = fa_c;
                count_d = count_q + CNT_W'(1);
                // On the MSB, carry_q is the carry into the sign bit.
                if (count_q == LAST_CNT) begin
                    state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sumhold_d  = sumsr_q;
                    couthold_d = carry_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sumsr_q    <= '0;
            carry_q    <= 1'b0;
            sumhold_q  <= '0;
            couthold_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sumsr_q    <= sumsr_d;
            carry_q    <= carry_d;
            sumhold_q  <= sumhold_d;
            couthold_q <= couthold_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Outside DONE the result outputs show the last delivered result.
    assign sum  = (state_q == S_DONE) ? sumsr_q : sumhold_q;
    assign cout = (state_q == S_DONE) ? carry_q : couthold_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid8, inReady8, outValid8, outReady8, ci8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       inValid1, inReady1, outValid1, outReady1, ci1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf1;
`endif
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .a_in(a8), .b_in(b8), .ci_in(ci8), .out_valid(outValid8),
        .out_ready(outReady8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
        .a_in(a1), .b_in(b1), .ci_in(ci1), .out_valid(outValid1),
        .out_ready(outReady1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; returns after the accept edge.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        inValid8 = 1'b1;
        a8 = a;
        b8 = b;
        ci8 = ci;
        tick();
        inValid8 = 1'b0;
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic ci);
        inValid1 = 1'b1;
        a1 = a;
        b1 = b;
        ci1 = ci;
        tick();
        inValid1 = 1'b0;
    endtask

    task automatic waitDone8(output int cyc);
        cyc = 0;
        while (outValid8 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic waitDone1(output int cyc);
        cyc = 0;
        while (outValid1 !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int       cyc;
        int       stall;
        logic [8:0] exp9;
        logic [1:0] exp2;
        logic [7:0] ra, rb;
        logic       rc, ea, eb;

        rst = 1'b1;
        inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        inValid1 = 1'b0; outReady1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(inReady8), 32'd1);
        checkOutput("rst_out_valid", 32'(outValid8), 32'd0);
        checkOutput("rst_sum", 32'(sum8), 32'd0);
        checkOutput("rst_cout", 32'(cout8), 32'd0);
        checkOutput("rst1_in_ready", 32'(inReady1), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("rst_ovf", 32'(ovf8), 32'd0);
`endif
        rst = 1'b0;
        tick();

        $display("[TB] 0x5A+0x3C latency and result, then 5-cycle stall");
        applyStimulus8(8'h5A, 8'h3C, 1'b0);
        checkOutput("shift_in_ready", 32'(inReady8), 32'd0);
        waitDone8(cyc);
        checkOutput("latency", 32'(cyc), 32'd8);
        checkOutput("t1_sum", 32'(sum8), 32'h96);
        checkOutput("t1_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("t1_ovf", 32'(ovf8), 32'd1);
`endif
        for (int i = 0; i < 5; i++) begin
            inValid8 = 1'b1;
            a8 = 8'hEE;
            tick();
            checkOutput("stall_valid", 32'(outValid8), 32'd1);
            checkOutput("stall_in_ready", 32'(inReady8), 32'd0);
            checkOutput("stall_sum", {23'd0, cout8, sum8}, 32'h096);
        end
        inValid8 = 1'b0;
        outReady8 = 1'b1;
        checkOutput("hs_in_ready", 32'(inReady8), 32'd0);
        tick();
        outReady8 = 1'b0;
        checkOutput("post_hs_valid", 32'(outValid8), 32'd0);
        checkOutput("post_hs_in_ready", 32'(inReady8), 32'd1);
        checkOutput("post_hs_sum_hold", 32'(sum8), 32'h96);

        $display("[TB] 0xFF+0x01 and 0+0+1");
        applyStimulus8(8'hFF, 8'h01, 1'b0);
        waitDone8(cyc);
        checkOutput("t2a_res", {23'd0, cout8, sum8}, 32'h100);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("t2a_ovf", 32'(ovf8), 32'd0);
`endif
        outReady8 = 1'b1;
        tick();
        outReady8 = 1'b0;
        applyStimulus8(8'h00, 8'h00, 1'b1);
        waitDone8(cyc);
        checkOutput("t2b_res", {23'd0, cout8, sum8}, 32'h001);
        outReady8 = 1'b1;
        tick();
        outReady8 = 1'b0;

        $display("[TB] in_valid pulse during SHIFT ignored");
        applyStimulus8(8'h12, 8'h34, 1'b1);
        tick();
        inValid8 = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0;
        tick();
        inValid8 = 1'b0;
        waitDone8(cyc);
        checkOutput("t4_latency", 32'(cyc), 32'd6);
        checkOutput("t4_res", {23'd0, cout8, sum8}, 32'h047);
        outReady8 = 1'b1;
        tick();
        outReady8 = 1'b0;

        $display("[TB] reset during SHIFT");
        applyStimulus8(8'hF0, 8'h0F, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_in_ready", 32'(inReady8), 32'd1);
        checkOutput("t5_out_valid", 32'(outValid8), 32'd0);
        checkOutput("t5_sum", {23'd0, cout8, sum8}, 32'h000);
        tick();
        checkOutput("t5_idle_valid", 32'(outValid8), 32'd0);

        $display("[TB] random WIDTH=8 ops");
        for (int n = 0; n < 400; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            outReady8 = 1'($urandom);
            applyStimulus8(ra, rb, rc);
            waitDone8(cyc);
            outReady8 = 1'b0;
            stall = $urandom_range(0, 3);
            repeat (stall) tick();
            checkOutput("r8_res", {23'd0, outValid8, cout8, sum8}, {23'd1, exp9});
`ifdef SERIAL_ADD_OVF_EN
            checkOutput("r8_ovf", 32'(ovf8), 32'((ra[7] == rb[7]) && (exp9[7] != ra[7])));
`endif
            outReady8 = 1'b1;
            tick();
            outReady8 = 1'b0;
        end

        $display("[TB] WIDTH=1 ops");
        for (int n = 0; n < 200; n++) begin
            ea = 1'($urandom);
            eb = 1'($urandom);
            rc = 1'($urandom);
            exp2 = {1'b0, ea} + {1'b0, eb} + {1'b0, rc};
            applyStimulus1(ea, eb, rc);
            waitDone1(cyc);
            checkOutput("w1_latency", 32'(cyc), 32'd1);
            checkOutput("w1_res", {30'd0, cout1, sum1}, {30'd0, exp2});
`ifdef SERIAL_ADD_OVF_EN
            checkOutput("w1_ovf", 32'(ovf1), 32'(rc ^ exp2[1]));
`endif
            stall = $urandom_range(0, 2);
            repeat (stall) tick();
            outReady1 = 1'b1;
            tick();
            outReady1 = 1'b0;
            checkOutput("w1_drop", 32'(outValid1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
